// File: rtl/uart_status_if.sv
// Request, snapshot fields and serial-line status between the processor core
// and the UART status reporter.
interface uart_status_if;
    logic       report_req;
    logic       harvest_alert;
    logic       fault_detected;
    logic [2:0] alert_level;
    logic [7:0] status_leds;
    logic       uart_tx;
    logic       busy;
    logic       done;

    modport master (
        output report_req, harvest_alert, fault_detected, alert_level, status_leds,
        input  uart_tx, busy, done
    );

    modport slave (
        input  report_req, harvest_alert, fault_detected, alert_level, status_leds,
        output uart_tx, busy, done
    );
endinterface

// File: rtl/uart_status_reporter.sv
// Snapshots processor result signals on request and sends them as a 5-byte
// 8N1 packet: sync, flags, leds, sequence number, XOR checksum.
module uart_status_reporter #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input logic          clk,
    input logic          rst_n,
    uart_status_if.slave bus
);

    localparam int unsigned    CntW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [2:0]      byte_q, byte_d;
    logic [7:0]      flags_q, flags_d;
    logic [7:0]      leds_q, leds_d;
    logic [7:0]      seq_q, seq_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic       bit_end;
    logic [2:0] bit_nxt;
    logic [7:0] checksum;
    logic [7:0] cur_byte;

    assign bit_end  = (baud_q == CntMax);
    assign bit_nxt  = bit_q + 3'd1;
    // seq_q only changes at completion, so it doubles as the latched sequence field.
    assign checksum = SYNC_BYTE ^ flags_q ^ leds_q ^ seq_q;

    always_comb begin
        cur_byte = SYNC_BYTE;
        case (byte_q)
            3'd0:    cur_byte = SYNC_BYTE;
            3'd1:    cur_byte = flags_q;
            3'd2:    cur_byte = leds_q;
            3'd3:    cur_byte = seq_q;
            3'd4:    cur_byte = checksum;
            default: cur_byte = SYNC_BYTE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        baud_d  = bit_end ? '0 : baud_q + CntW'(1);
        bit_d   = bit_q;
        byte_d  = byte_q;
        flags_d = flags_q;
        leds_d  = leds_q;
        seq_d   = seq_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (bus.report_req) begin
                    flags_d = {bus.harvest_alert, bus.fault_detected, 3'b000, bus.alert_level};
                    leds_d  = bus.status_leds;
                    byte_d  = 3'd0;
                    busy_d  = 1'b1;
                    tx_d    = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    bit_d   = 3'd0;
                    tx_d    = cur_byte[0];
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = cur_byte[bit_nxt];
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (byte_q == 3'd4) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        seq_d   = seq_q + 8'd1;
                        state_d = StIdle;
                    end else begin
                        // Next start bit follows the stop bit with no idle gap.
                        byte_d  = byte_q + 3'd1;
                        tx_d    = 1'b0;
                        state_d = StStart;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 3'd0;
            flags_q <= 8'h00;
            leds_q  <= 8'h00;
            seq_q   <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            flags_q <= flags_d;
            leds_q  <= leds_d;
            seq_q   <= seq_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.uart_tx = tx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_uart_status_reporter.sv
// Drives status reports into the UART reporter, decodes the serial line with a
// sampling receiver and compares every frame against a packet-level model.
module tb_uart_status_reporter;

    localparam int unsigned CPB = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   seq_model = 0;
    int   rx_framing_err = 0;
    logic [7:0] rx_q[$];

    uart_status_if dif ();

    uart_status_reporter #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (dif)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] build_pkt(input logic h, input logic f,
                                              input logic [2:0] lvl, input logic [7:0] leds,
                                              input logic [7:0] seq);
        logic [7:0] b[5];
        b[0] = 8'hA5;
        b[1] = {h, f, 3'b000, lvl};
        b[2] = leds;
        b[3] = seq;
        b[4] = b[0] ^ b[1] ^ b[2] ^ b[3];
        return {b[4], b[3], b[2], b[1], b[0]};
    endfunction

    // Line receiver: samples each bit mid-cell; abandons a frame if reset is seen.
    initial begin
        logic [7:0] rx_byte;
        logic       rx_ok;
        rx_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && dif.uart_tx === 1'b0) begin
                rx_ok = 1'b1;
                repeat (CPB / 2) begin
                    @(negedge clk);
                    if (!rst_n) rx_ok = 1'b0;
                end
                if (dif.uart_tx !== 1'b0) rx_ok = 1'b0;
                for (int i = 0; i < 9 && rx_ok; i++) begin
                    repeat (CPB) begin
                        @(negedge clk);
                        if (!rst_n) rx_ok = 1'b0;
                    end
                    if (i < 8) rx_byte[i] = dif.uart_tx;
                    else if (rx_ok && dif.uart_tx !== 1'b1) rx_framing_err++;
                end
                if (rx_ok) rx_q.push_back(rx_byte);
            end
        end
    end

    task automatic set_fields(input logic h, input logic f, input logic [2:0] lvl,
                              input logic [7:0] leds);
        dif.harvest_alert  = h;
        dif.fault_detected = f;
        dif.alert_level    = lvl;
        dif.status_leds    = leds;
    endtask

    // Called at a negedge with the reporter idle; returns at the done cycle's negedge.
    task automatic run_packet(input logic h, input logic f, input logic [2:0] lvl,
                              input logic [7:0] leds, input bit keep_req, input int poke_at);
        logic [39:0] exp;
        int          cyc;
        bit          seen;
        set_fields(h, f, lvl, leds);
        dif.report_req = 1'b1;
        exp = build_pkt(h, f, lvl, leds, 8'(seq_model));
        @(posedge clk);
        #1;
        check_val("start_bit", dif.uart_tx, 1'b0);
        check_val("busy_rise", dif.busy, 1'b1);
        cyc  = 0;
        seen = 1'b0;
        for (int n = 0; n < 60 * CPB && !seen; n++) begin
            @(negedge clk);
            if (dif.done === 1'b1) seen = 1'b1;
            else begin
                if (dif.busy === 1'b1) cyc++;
                if (!keep_req) dif.report_req = (cyc == poke_at);
                if (cyc == poke_at)
                    set_fields(1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom));
            end
        end
        check_val("done_seen", seen, 1'b1);
        check_val("frame_len", cyc, 50 * CPB);
        check_val("busy_fall", dif.busy, 1'b0);
        check_val("idle_gap_tx", dif.uart_tx, 1'b1);
        check_val("rx_count", rx_q.size(), 5);
        for (int i = 0; i < 5 && rx_q.size() > 0; i++)
            check_val($sformatf("byte%0d_seq%0d", i, seq_model), rx_q.pop_front(), exp[8*i+:8]);
        rx_q.delete();
        seq_model = (seq_model + 1) % 256;
        if (!keep_req) begin
            dif.report_req = 1'b0;
            @(negedge clk);
            check_val("done_width", dif.done, 1'b0);
            check_val("no_requeue", dif.busy, 1'b0);
        end
    endtask

    initial begin
        int dones;
        int tx_low;
        rst_n = 1'b0;
        dif.report_req = 1'b0;
        set_fields(1'b0, 1'b0, 3'd0, 8'h00);
        repeat (3) @(negedge clk);
        check_val("rst_tx", dif.uart_tx, 1'b1);
        check_val("rst_busy", dif.busy, 1'b0);
        check_val("rst_done", dif.done, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("idle_tx", dif.uart_tx, 1'b1);
        check_val("idle_busy", dif.busy, 1'b0);

        // Basic packet and a repeat with identical inputs.
        run_packet(1'b1, 1'b0, 3'b101, 8'h3C, 1'b0, -1);
        run_packet(1'b1, 1'b0, 3'b101, 8'h3C, 1'b0, -1);

        // Inputs and a new request mid-frame must not disturb the packet in flight.
        run_packet(1'b1, 1'b0, 3'b101, 8'h3C, 1'b0, 57);
        dones = 0;
        repeat (10) begin
            @(negedge clk);
            if (dif.done === 1'b1) dones++;
        end
        check_val("extra_done", dones, 0);
        check_val("extra_busy", dif.busy, 1'b0);

        // Continuous request: packets separated by a single idle cycle.
        run_packet(1'b0, 1'b1, 3'b010, 8'h81, 1'b1, -1);
        run_packet(1'b0, 1'b1, 3'b010, 8'h81, 1'b1, -1);
        run_packet(1'b0, 1'b1, 3'b010, 8'h81, 1'b0, -1);

        for (int k = 0; k < 8; k++)
            run_packet(1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom), 1'b0,
                       int'($urandom_range(1, 50 * CPB - 2)));

        // Run until the sequence counter wraps FF -> 00.
        while (seq_model != 0)
            run_packet(1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom),
                       (seq_model != 255), -1);

        // Reset during byte 2's data bits aborts the frame without a done pulse.
        set_fields(1'b1, 1'b1, 3'b111, 8'h55);
        dif.report_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dif.report_req = 1'b0;
        repeat (95) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("abort_tx", dif.uart_tx, 1'b1);
        check_val("abort_busy", dif.busy, 1'b0);
        check_val("abort_done", dif.done, 1'b0);
        dones  = 0;
        tx_low = 0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (dif.done === 1'b1) dones++;
            if (dif.uart_tx !== 1'b1) tx_low++;
        end
        check_val("abort_no_done", dones, 0);
        check_val("abort_line_idle", tx_low, 0);
        rx_q.delete();
        seq_model = 0;
        run_packet(1'b0, 1'b0, 3'b011, 8'hE7, 1'b0, -1);

        check_val("framing_errors", rx_framing_err, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_status_reporter.md
Name: uart_status_reporter

Overview:
- UART transmit side of the farming ASIC's debug/config serial link, driving the uart_tx line of the main processor.
- On request, snapshots the processor's result signals (harvest alert, alert level, status LEDs, fault flag) and frames them into a fixed 5-byte packet.
- Serializes the packet as 8N1 at a fixed baud rate derived from the system clock.
- Lets a host logging the serial line read classification results without using the dedicated output pins.

Parameters:
- CLKS_PER_BIT, 87, system clock cycles per UART bit; legal range >= 2 (87 gives ~115200 baud at 10 MHz).
- SYNC_BYTE, 8'hA5, value of packet byte 0.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- report_req  input  1  level-sampled request; accepted only when busy=0.
- harvest_alert  input  1  snapshot field.
- fault_detected  input  1  snapshot field.
- alert_level  input  3  snapshot field.
- status_leds  input  8  snapshot field.
- uart_tx  output  1  serial line; idle high; registered.
- busy  output  1  high while a packet is in flight.
- done  output  1  one-cycle pulse at packet completion.

Behaviour:
- Reset (async assert, sync-free release): uart_tx=1, busy=0, done=0, seq counter=0, FSM=IDLE, all counters cleared. Reset mid-packet aborts immediately; the line returns high with no partial stop bit, and no done pulse is issued.
- Packet format, bytes sent in order 0..4:
  - byte0 = SYNC_BYTE.
  - byte1 = {harvest_alert, fault_detected, 3'b000, alert_level}.
  - byte2 = status_leds.
  - byte3 = seq (8-bit packet counter).
  - byte4 = XOR of bytes 0..3.
- Snapshot: all fields and seq are latched in the accept cycle. Input changes afterwards do not affect the packet in flight.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If report_req=1 at a rising edge: latch snapshot, busy<=1, uart_tx<=0, go to START. Latency is 1 cycle from the sampled request to the start bit.
  - START: hold 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles, then go to STOP.
  - STOP: hold 1 for CLKS_PER_BIT cycles. If more bytes remain, advance the byte index and go to START with no idle gap. After byte 4, return to IDLE.
- Completion: at the edge ending byte 4's stop bit, busy<=0, done<=1 for exactly one cycle, and seq<=seq+1 (wraps 0xFF->0x00).
- Frame length is exactly 50*CLKS_PER_BIT cycles from the start-bit edge to the busy-fall edge.
- Baud counter counts 0..CLKS_PER_BIT-1 and reloads on every bit boundary. Its width is $clog2(CLKS_PER_BIT).
- report_req while busy=1, including the done cycle, is ignored and not queued.
- report_req sampled high in the cycle after done (busy=0) is accepted. Back-to-back packets are therefore separated by exactly one idle-high cycle.
- report_req held high continuously produces a packet, one idle cycle, then the next packet, with seq incrementing each time.
- uart_tx is driven from a flop (glitch-free). busy and done are flops.

Test Plan:
- Basic packet (CLKS_PER_BIT=4): harvest=1, fault=0, level=3'b101, leds=0x3C, pulse report_req → decode bytes A5,85,3C,00,1C. Check start bit at the first edge after req, busy high for 200 cycles, then a single done pulse.
- Second packet with identical inputs → bytes A5,85,3C,01,1D; seq incremented, checksum updated.
- Snapshot/ignore: accept a request, then change leds to 0xFF and pulse report_req mid-frame → packet still carries 0x3C. Exactly one packet is sent, one done pulse occurs, and seq advances by 1.
- Continuous report_req high for 3 packets → seq 00,01,02. Exactly one idle-high cycle between each stop bit and the next start bit.
- Seq wrap: force 256 packets (or preload by running) → packet 256 carries seq=FF, packet 257 carries seq=00 with checksum recomputed.
- Reset mid-frame during byte 2 DATA: assert rst_n=0 → uart_tx=1 and busy=0 asynchronously, with no done pulse. After release, the next packet has seq=00 and a correct frame.
